pipe_hazard_ctrl: RTL



---
 rtl/pipe_ctrl_pkg.sv | 15 +
 rtl/sat_counter.sv | 37 +++
 rtl/pipe_hazard_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: state
// encoding and register-index constants.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_WARMUP   = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ILLEGAL  = 2'd3
  } state_e;

  localparam int unsigned REG_AW = 5;
  localparam logic [REG_AW-1:0] X0 = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear. Clear and increment in the
// same cycle restart the count at one.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         CLK,
  input  logic         CLR_N,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = W'(inc);
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: stage enables,
// bubble clears, post-reset warm-up and stall/flush performance counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned WARMUP_CYCLES = 4,
  parameter int unsigned TIMEOUT       = 255,
  parameter int unsigned CNT_W         = 16
) (
  input  logic              CLK,
  input  logic              CLR_N,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_br_taken,
  input  logic              imem_ready,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              idex_en,
  output logic              exmem_en,
  output logic              memwb_en,
  output logic              ifid_clr,
  output logic              idex_clr,
  output logic              exmem_clr,
  output logic              memwb_clr,
  output logic [1:0]        state,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [3:0] WARM_INIT = 4'(WARMUP_CYCLES - 1);
  localparam logic [7:0] TMO_VAL   = 8'(TIMEOUT);

  state_e     state_q, state_d;
  logic [3:0] warm_q, warm_d;
  logic       mem_timeout_q, mem_timeout_d;
  logic [7:0] wait_cnt;

  logic mem_stall, load_use, tmo_hit;
  logic do_mem, do_run, br_flush;
  logic wait_clr, wait_inc;

  assign mem_stall = dmem_req && !dmem_ready;
  assign load_use  = ex_mem_read && (ex_rd != X0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                      (id_use_rs2 && (id_rs2 == ex_rd)));
  assign tmo_hit   = (state_q == ST_MEM_WAIT) && (wait_cnt == TMO_VAL);

  // NOTE: every output and next-state value gets a default before any
  // branch, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    pc_en     = 1'b1;
    ifid_en   = 1'b1;
    idex_en   = 1'b1;
    exmem_en  = 1'b1;
    memwb_en  = 1'b1;
    ifid_clr  = 1'b0;
    idex_clr  = 1'b0;
    exmem_clr = 1'b0;
    memwb_clr = 1'b0;
    state_d   = state_q;
    warm_d    = warm_q;
    do_mem    = 1'b0;
    do_run    = 1'b0;
    br_flush  = 1'b0;
    wait_clr  = 1'b1;
    wait_inc  = 1'b0;

    case (state_q)
      ST_WARMUP: begin
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
        {ifid_clr, idex_clr, exmem_clr, memwb_clr}    = '1;
        if (warm_q == 4'd0) begin
          state_d = ST_RUN;
        end else begin
          warm_d = warm_q - 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_stall) begin
          do_mem   = 1'b1;
          wait_clr = 1'b0;
          wait_inc = 1'b1;
        end else begin
          // Release cycle: normal arbitration without the memory stall term.
          do_run  = 1'b1;
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
        if (mem_stall) begin
          do_mem = 1'b1;
          if (state_q == ST_RUN) begin
            state_d  = ST_MEM_WAIT;
            wait_inc = 1'b1;
          end
        end else begin
          do_run = 1'b1;
        end
      end
    endcase

    if (do_mem) begin
      {pc_en, ifid_en, idex_en, exmem_en} = '0;
      memwb_clr = 1'b1;
    end else if (do_run) begin
      if (ex_br_taken) begin
        ifid_clr = 1'b1;
        idex_clr = 1'b1;
        br_flush = 1'b1;
      end else if (load_use) begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_clr = 1'b1;
      end else if (!imem_ready) begin
        pc_en    = 1'b0;
        ifid_clr = 1'b1;
      end
    end

    // Reset holds the pipeline frozen and cleared before the first edge lands.
    if (!CLR_N) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
      {ifid_clr, idex_clr, exmem_clr, memwb_clr}    = '1;
    end
  end

  assign mem_timeout_d = mem_timeout_q | tmo_hit;

  // NOTE: CLR_N is sampled on the clock edge only; it never appears in the
  // sensitivity list, so the reset path is fully synchronous.
  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      state_q       <= ST_WARMUP;
      warm_q        <= WARM_INIT;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      warm_q        <= warm_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .CLR_N (CLR_N),
    .clr   (1'b0),
    .inc   (!pc_en && (state_q != ST_WARMUP)),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .CLR_N (CLR_N),
    .clr   (1'b0),
    .inc   (br_flush),
    .cnt   (flush_cnt)
  );

  sat_counter #(.W(8)) u_wait_cnt (
    .CLK   (CLK),
    .CLR_N (CLR_N),
    .clr   (wait_clr),
    .inc   (wait_inc),
    .cnt   (wait_cnt)
  );

  assign state       = state_q;
  assign mem_timeout = mem_timeout_q | tmo_hit;

endmodule
